// File: rtl/sobel_pkg.sv
// Shared constants, phase type and saturation helper for the Sobel edge engine.
//
// Contents:
//   PIX_W, WORD_PIX  pixel width and pixels per 64-bit word
//   ROW_WORDS        words per frame row
//   ADDR_W, DATA_W   word address and data widths
//   WIN_ROWS         rows captured per column group
//   SLICE_W          one kernel row slice: a word plus its left/right neighbour
//   phase_t          capture phase within a column group
//   sat_u8()         clamps an unsigned magnitude to 8 bits
package sobel_pkg;

    localparam int unsigned PIX_W     = 8;
    localparam int unsigned WORD_PIX  = 8;
    localparam int unsigned ROW_WORDS = 256;
    localparam int unsigned ADDR_W    = 20;
    localparam int unsigned DATA_W    = PIX_W * WORD_PIX;
    localparam int unsigned WIN_ROWS  = 4;
    localparam int unsigned SLICE_W   = (WORD_PIX + 2) * PIX_W;

    // PH_R0 captures row r, PH_R1 row r-1, PH_R2 row r-2, PH_R3 row r-3.
    typedef enum logic [1:0] {PH_R0, PH_R1, PH_R2, PH_R3} phase_t;

    function automatic logic [PIX_W-1:0] sat_u8(input logic [11:0] v);
        return (v > 12'd255) ? 8'hFF : v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sobel_kernel8.sv
// Combinational 3x3 Sobel magnitude for eight adjacent pixels.
//
// Each row slice carries 10 pixels: pixel 0 is the left neighbour, pixels 1..8
// are the word being filtered (byte 0 leftmost), pixel 9 is the right neighbour.
// Output byte i is |Gx| + |Gy| for slice pixel i+1, saturated to 255.
//
// Build option: with SOBEL_THRESH_EN defined every output byte becomes 8'hFF when
// the saturated magnitude is >= THRESHOLD and 8'h00 otherwise.
//
// Ports:
//   row_top  in  80  row above the centre row
//   row_mid  in  80  centre row
//   row_bot  in  80  row below the centre row
//   mag      out 64  eight magnitudes, byte 0 leftmost
module sobel_kernel8
    import sobel_pkg::*;
#(
    parameter int unsigned THRESHOLD = 128
) (
    input  logic [SLICE_W-1:0] row_top,
    input  logic [SLICE_W-1:0] row_mid,
    input  logic [SLICE_W-1:0] row_bot,
    output logic [DATA_W-1:0]  mag
);

    function automatic logic signed [10:0] sx(input logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

`ifndef SOBEL_THRESH_EN
    logic unused_thresh;
    assign unused_thresh = ^THRESHOLD;
`endif

    for (genvar i = 0; i < WORD_PIX; i++) begin : g_pix
        logic [PIX_W-1:0]   t0, t1, t2, m0, m2, b0, b1, b2;
        logic signed [10:0] gx, gy;
        logic [10:0]        ax, ay;
        logic [11:0]        sum;
        logic [PIX_W-1:0]   sat;

        assign t0 = row_top[i*PIX_W +: PIX_W];
        assign t1 = row_top[(i+1)*PIX_W +: PIX_W];
        assign t2 = row_top[(i+2)*PIX_W +: PIX_W];
        assign m0 = row_mid[i*PIX_W +: PIX_W];
        assign m2 = row_mid[(i+2)*PIX_W +: PIX_W];
        assign b0 = row_bot[i*PIX_W +: PIX_W];
        assign b1 = row_bot[(i+1)*PIX_W +: PIX_W];
        assign b2 = row_bot[(i+2)*PIX_W +: PIX_W];

        // Both gradients lie in [-1020, 1020], so 11-bit signed never overflows.
        always_comb begin
            gx  = (sx(t2) + (sx(m2) <<< 1) + sx(b2)) - (sx(t0) + (sx(m0) <<< 1) + sx(b0));
            gy  = (sx(b0) + (sx(b1) <<< 1) + sx(b2)) - (sx(t0) + (sx(t1) <<< 1) + sx(t2));
            ax  = gx[10] ? $unsigned(-gx) : $unsigned(gx);
            ay  = gy[10] ? $unsigned(-gy) : $unsigned(gy);
            sum = {1'b0, ax} + {1'b0, ay};
            sat = sat_u8(sum);
        end

`ifdef SOBEL_THRESH_EN
        assign mag[i*PIX_W +: PIX_W] = ({4'b0000, sat} >= 12'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
        assign mag[i*PIX_W +: PIX_W] = sat;
`endif
    end

endmodule

// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge-magnitude engine for 8-bit greyscale frames stored
// eight pixels per 64-bit word (column = addr[7:0], row = addr[19:8]).
//
// The scheduler reads a column group as rows r, r-1, r-2, r-3 of column c, one
// word per clock. When the last word of a group lands, the column is pushed into
// a three-column window and, one clock later, column c-1 is written for centre
// rows r-2 (port 2) and r-1 (port 3). Column 0 groups write nothing; a column 255
// group also writes column 255 on the following clock with the right edge
// replicated.
//
// Build option: SOBEL_THRESH_EN binarizes each magnitude against THRESHOLD.
//
// Ports:
//   clk       in   1   rising-edge clock
//   reset     in   1   synchronous, active-low
//   startEn   in   1   start pulse; restarts the phase counter
//   rd_addr   in   20  address presented to the source RAM this cycle
//   rd_data   in   64  source RAM data for the previous cycle's address
//   we2/we3   out  1   write enables for the upper/lower centre row results
//   wr_addr2  out  20  result address, port 2
//   wr_data2  out  64  eight magnitudes, port 2
//   wr_addr3  out  20  result address, port 3
//   wr_data3  out  64  eight magnitudes, port 3
//   getNext   out  1   column group complete
module sobel_filter #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned ROW_WORDS = 256,
    parameter int unsigned THRESHOLD = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              startEn,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              we2,
    output logic              we3,
    output logic [ADDR_W-1:0] wr_addr2,
    output logic [DATA_W-1:0] wr_data2,
    output logic [ADDR_W-1:0] wr_addr3,
    output logic [DATA_W-1:0] wr_data3,
    output logic              getNext
);

    import sobel_pkg::*;

    localparam int unsigned       COL_W    = $clog2(ROW_WORDS);
    localparam int unsigned       ROW_W    = ADDR_W - COL_W;
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(ROW_WORDS - 1);
    localparam logic [COL_W-1:0]  FIRST_OUT_COL = COL_W'(1);

    logic [ADDR_W-1:0] addr_d;
    logic              running;
    phase_t            phase;

    // Words of the group still in flight (rows r, r-1, r-2).
    logic [DATA_W-1:0] stage [WIN_ROWS-1];
    logic [ROW_W-1:0]  grp_row;
    logic [COL_W-1:0]  grp_col;

    // Window, indexed by row offset (0 = row r ... 3 = row r-3). Only the
    // rightmost pixel of column c-2 is ever needed, so just that byte is kept.
    logic [PIX_W-1:0]  old_px  [WIN_ROWS];
    logic [DATA_W-1:0] mid_col [WIN_ROWS];
    logic [DATA_W-1:0] cur_col [WIN_ROWS];

    logic              emit_pend;
    logic              clamp_pend;
    logic [ROW_W-1:0]  em_row;
    logic [COL_W-1:0]  em_col;

    logic [SLICE_W-1:0] slice [WIN_ROWS];
    logic [DATA_W-1:0]  mag2, mag3;

    // Build the 10-pixel slice per row for the column being emitted.
    always_comb begin
        for (int j = 0; j < WIN_ROWS; j++) begin
            slice[j] = '0;
            if (clamp_pend) begin
                // Column 255: right neighbour replicates pixel 2047.
                slice[j] = {cur_col[j][DATA_W-1 -: PIX_W], cur_col[j],
                            mid_col[j][DATA_W-1 -: PIX_W]};
            end else if (em_col == FIRST_OUT_COL) begin
                // Column 0: left neighbour replicates pixel 0.
                slice[j] = {cur_col[j][PIX_W-1:0], mid_col[j], mid_col[j][PIX_W-1:0]};
            end else begin
                slice[j] = {cur_col[j][PIX_W-1:0], mid_col[j], old_px[j]};
            end
        end
    end

    sobel_kernel8 #(
        .THRESHOLD (THRESHOLD)
    ) u_kernel_2 (
        .row_top (slice[3]),
        .row_mid (slice[2]),
        .row_bot (slice[1]),
        .mag     (mag2)
    );

    sobel_kernel8 #(
        .THRESHOLD (THRESHOLD)
    ) u_kernel_3 (
        .row_top (slice[2]),
        .row_mid (slice[1]),
        .row_bot (slice[0]),
        .mag     (mag3)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_d     <= '0;
            running    <= 1'b0;
            phase      <= PH_R0;
            grp_row    <= '0;
            grp_col    <= '0;
            em_row     <= '0;
            em_col     <= '0;
            emit_pend  <= 1'b0;
            clamp_pend <= 1'b0;
            for (int j = 0; j < WIN_ROWS - 1; j++) begin
                stage[j] <= '0;
            end
            for (int j = 0; j < WIN_ROWS; j++) begin
                old_px[j]  <= '0;
                mid_col[j] <= '0;
                cur_col[j] <= '0;
            end
            we2      <= 1'b0;
            we3      <= 1'b0;
            getNext  <= 1'b0;
            wr_addr2 <= '0;
            wr_addr3 <= '0;
            wr_data2 <= '0;
            wr_data3 <= '0;
        end else begin
            addr_d     <= rd_addr;
            emit_pend  <= 1'b0;
            clamp_pend <= 1'b0;
            we2        <= 1'b0;
            we3        <= 1'b0;
            getNext    <= 1'b0;

            // A start pulse drops any partially captured group; the window stays.
            if (startEn) begin
                running <= 1'b1;
                phase   <= PH_R0;
            end else if (running) begin
                unique case (phase)
                    PH_R0: begin
                        stage[0] <= rd_data;
                        grp_row  <= addr_d[ADDR_W-1:COL_W];
                        grp_col  <= addr_d[COL_W-1:0];
                        phase    <= PH_R1;
                    end
                    PH_R1: begin
                        stage[1] <= rd_data;
                        phase    <= PH_R2;
                    end
                    PH_R2: begin
                        stage[2] <= rd_data;
                        phase    <= PH_R3;
                    end
                    PH_R3: begin
                        for (int j = 0; j < WIN_ROWS; j++) begin
                            old_px[j]  <= mid_col[j][DATA_W-1 -: PIX_W];
                            mid_col[j] <= cur_col[j];
                        end
                        cur_col[0] <= stage[0];
                        cur_col[1] <= stage[1];
                        cur_col[2] <= stage[2];
                        cur_col[3] <= rd_data;
                        emit_pend  <= 1'b1;
                        em_row     <= grp_row;
                        em_col     <= grp_col;
                        phase      <= PH_R0;
                    end
                    default: phase <= PH_R0;
                endcase
            end

            if (emit_pend) begin
                getNext    <= 1'b1;
                clamp_pend <= (em_col == LAST_COL);
                if (em_col != '0) begin
                    we2      <= 1'b1;
                    we3      <= 1'b1;
                    wr_addr2 <= {em_row - ROW_W'(2), em_col - COL_W'(1)};
                    wr_addr3 <= {em_row - ROW_W'(1), em_col - COL_W'(1)};
                    wr_data2 <= mag2;
                    wr_data3 <= mag3;
                end
            end else if (clamp_pend) begin
                we2      <= 1'b1;
                we3      <= 1'b1;
                wr_addr2 <= {em_row - ROW_W'(2), LAST_COL};
                wr_addr3 <= {em_row - ROW_W'(1), LAST_COL};
                wr_data2 <= mag2;
                wr_data3 <= mag3;
            end
        end
    end

endmodule

// File: tb/tb_sobel_filter.sv
// Self-checking bench for sobel_filter: a source RAM model feeds column groups
// from a small frame image; every write and getNext pulse is compared, cycle by
// cycle, against a pixel-level Sobel reference computed from the image.
module tb_sobel_filter;

    localparam int NROWS = 8;
    localparam int NPIX  = 2048;

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        startEn = 1'b0;
    logic [19:0] rd_addr = '0;
    logic [63:0] rd_data = '0;
    logic        we2, we3, getNext;
    logic [19:0] wr_addr2, wr_addr3;
    logic [63:0] wr_data2, wr_data3;

    sobel_filter dut (
        .clk      (clk),
        .reset    (reset),
        .startEn  (startEn),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .we2      (we2),
        .we3      (we3),
        .wr_addr2 (wr_addr2),
        .wr_data2 (wr_data2),
        .wr_addr3 (wr_addr3),
        .wr_data3 (wr_data3),
        .getNext  (getNext)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic        w2;
        logic        w3;
        logic [19:0] a2;
        logic [19:0] a3;
        logic [63:0] d2;
        logic [63:0] d3;
    } wr_t;

    logic [7:0] img [NROWS][NPIX];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    int  e0 = 0;
    int  grp_r[$];
    int  grp_c[$];
    wr_t obs_wr[$];
    int  obs_gn[$];
    wr_t fw[$];

    function automatic logic [63:0] word_at(input logic [19:0] a);
        logic [63:0] w = '0;
        int r = int'(a[19:8]);
        int c = int'(a[7:0]);
        if (r < NROWS) for (int i = 0; i < 8; i++) w[8*i +: 8] = img[r][8*c+i];
        return w;
    endfunction

    // Source RAM: one-cycle registered read.
    always @(posedge clk) rd_data <= word_at(rd_addr);
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (we2 || we3) obs_wr.push_back('{cyc, we2, we3, wr_addr2, wr_addr3, wr_data2, wr_data3});
        if (getNext) obs_gn.push_back(cyc);
    end

    // Reference: pixel access with edge replication, then the Sobel definition.
    function automatic int px(input int r, input int x);
        int xc = (x < 0) ? 0 : ((x > NPIX - 1) ? NPIX - 1 : x);
        return int'(img[r][xc]);
    endfunction

    function automatic logic [7:0] ref_mag(input int r, input int x);
        int gx, gy, m;
        gx = (px(r-1, x+1) + 2*px(r, x+1) + px(r+1, x+1))
           - (px(r-1, x-1) + 2*px(r, x-1) + px(r+1, x-1));
        gy = (px(r+1, x-1) + 2*px(r+1, x) + px(r+1, x+1))
           - (px(r-1, x-1) + 2*px(r-1, x) + px(r-1, x+1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
        return (m >= 128) ? 8'hFF : 8'h00;
`else
        return 8'(m);
`endif
    endfunction

    function automatic logic [63:0] ref_word(input int r, input int col);
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_mag(r, 8*col + i);
        return w;
    endfunction

    function automatic wr_t mk(input int t, input int r, input int col);
        return '{t, 1'b1, 1'b1, {12'(r-2), 8'(col)}, {12'(r-1), 8'(col)},
                 ref_word(r-2, col), ref_word(r-1, col)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < NROWS; r++)
            for (int x = 0; x < NPIX; x++)
                case (kind)
                    0: img[r][x] = 8'h80;
                    1: img[r][x] = (x / 8 >= 128) ? 8'hFF : 8'h00;
                    2: img[r][x] = (r >= 2) ? 8'hFF : 8'h00;
                    default: img[r][x] = 8'($urandom);
                endcase
    endtask

    task automatic add_pass(input int r, input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            grp_r.push_back(r);
            grp_c.push_back(c);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b0;
        startEn = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        grp_r.delete();
        grp_c.delete();
    endtask

    task automatic drive_word(input int r, input int c, input logic st);
        @(negedge clk);
        startEn = st;
        rd_addr = {12'(r), 8'(c)};
    endtask

    // Streams the queued groups (startEn on the first word) and compares every
    // write and getNext pulse against the reference timing and data.
    task automatic run_groups(input string name);
        int  ng, lim, t;
        wr_t ew[$];
        int  eg[$];
        int  fg[$];
        ng = grp_r.size();
        for (int k = 0; k < 4 * ng; k++) begin
            @(negedge clk);
            if (k == 0) begin
                obs_wr.delete();
                obs_gn.delete();
                e0 = cyc + 1;
            end
            startEn = (k == 0);
            rd_addr = {12'(grp_r[k/4] - k % 4), 8'(grp_c[k/4])};
        end
        repeat (6) @(negedge clk);
        lim = e0 + 4 * ng + 3;
        for (int g = 0; g < ng; g++) begin
            t = e0 + 4 * g + 5;
            eg.push_back(t);
            if (grp_c[g] > 0) ew.push_back(mk(t, grp_r[g], grp_c[g] - 1));
            if (grp_c[g] == 255) ew.push_back(mk(t + 1, grp_r[g], 255));
        end
        fw.delete();
        foreach (obs_wr[i]) if (obs_wr[i].c >= e0 && obs_wr[i].c <= lim) fw.push_back(obs_wr[i]);
        foreach (obs_gn[i]) if (obs_gn[i] >= e0 && obs_gn[i] <= lim) fg.push_back(obs_gn[i]);
        chk({name, " write count"}, 64'(fw.size()), 64'(ew.size()));
        chk({name, " getNext count"}, 64'(fg.size()), 64'(eg.size()));
        for (int i = 0; i < fw.size() && i < ew.size(); i++) begin
            chk($sformatf("%s wr%0d cycle", name, i), 64'(fw[i].c - e0), 64'(ew[i].c - e0));
            chk($sformatf("%s wr%0d we2", name, i), 64'(fw[i].w2), 64'(1));
            chk($sformatf("%s wr%0d we3", name, i), 64'(fw[i].w3), 64'(1));
            chk($sformatf("%s wr%0d addr2", name, i), 64'(fw[i].a2), 64'(ew[i].a2));
            chk($sformatf("%s wr%0d addr3", name, i), 64'(fw[i].a3), 64'(ew[i].a3));
            chk($sformatf("%s wr%0d data2", name, i), fw[i].d2, ew[i].d2);
            chk($sformatf("%s wr%0d data3", name, i), fw[i].d3, ew[i].d3);
        end
        for (int i = 0; i < fg.size() && i < eg.size(); i++)
            chk($sformatf("%s getNext%0d cycle", name, i), 64'(fg[i] - e0), 64'(eg[i] - e0));
    endtask

    task automatic chk_idle(input string name);
        chk({name, " we2"}, 64'(we2), 64'(0));
        chk({name, " we3"}, 64'(we3), 64'(0));
        chk({name, " getNext"}, 64'(getNext), 64'(0));
        chk({name, " wr_addr2"}, 64'(wr_addr2), 64'(0));
        chk({name, " wr_addr3"}, 64'(wr_addr3), 64'(0));
        chk({name, " wr_data2"}, wr_data2, 64'(0));
        chk({name, " wr_data3"}, wr_data3, 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic found;

        // Reset state.
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b1;

        // Flat frame, full pass starting at address 768 (row 3, column 0).
        fill(0);
        do_reset();
        add_pass(3, 0, 255);
        run_groups("flat");

        // Vertical step between word columns 127 and 128.
        fill(1);
        do_reset();
        add_pass(3, 0, 255);
        run_groups("vstep");
        found = 1'b0;
        foreach (fw[i]) if (fw[i].a2[7:0] == 8'd127) begin
            found = 1'b1;
            chk("vstep col127 data2", fw[i].d2, 64'hFF00_0000_0000_0000);
        end
        chk("vstep col127 present", 64'(found), 64'(1));

        // Horizontal step: centre row 1 sees dark above, bright below.
        fill(2);
        do_reset();
        add_pass(3, 0, 40);
        run_groups("hstep");
        if (fw.size() > 5) begin
            chk("hstep port2 data", fw[5].d2, '1);
            chk("hstep port2 addr", 64'(fw[5].a2), 64'(256 + 5));
        end else begin
            chk("hstep writes present", 64'(fw.size()), 64'(6));
        end

        // Random frame, two back-to-back passes (row wrap after column 255).
        fill(3);
        do_reset();
        add_pass(3, 0, 255);
        add_pass(4, 0, 255);
        run_groups("rand2pass");

        // startEn mid-group re-aligns; window contents carry over.
        do_reset();
        for (int k = 0; k < 15; k++) drive_word(6 - k % 4, k / 4, k == 0);
        add_pass(6, 3, 40);
        run_groups("realign");

        // Reset while a write is pending: nothing may be written afterwards.
        do_reset();
        for (int k = 0; k < 37; k++) drive_word(5 - k % 4, k / 4, k == 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("midreset");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("midreset hold%0d we", k), 64'(we2 | we3 | getNext), 64'(0));
        end
        reset = 1'b1;
        grp_r.delete();
        grp_c.delete();
        add_pass(5, 0, 20);
        run_groups("postreset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
